// File: rtl/rob_retire_ctl.sv
// rob_retire_ctl: reorder-buffer allocate/retire/flush controller with wrap-bit head and tail pointers.
// Ports: clk, reset_n (async active-low).
//   Decode side: alloc_req_de1, alloc_gnt_de1, alloc_robid_de1, e_alloc_vec_de1.
//   Entry status inputs: e_valid_vec, e_ready_vec, e_flush_needed_vec.
//   Retire side: e_retire_vec_rb1, retire_valid_rb1, retire_robid_rb1, q_flush_now_rb1.
//   Occupancy: rob_full, rob_empty, rob_count.
//   With ROB_PERF_CNT_EN defined, the module adds saturating perf_retire_cnt and perf_flush_cnt.
module rob_retire_ctl #(
    parameter int ROB_DEPTH = 16,
    parameter int IDW = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc_req_de1,
    output logic                 alloc_gnt_de1,
    output logic [IDW-1:0]       alloc_robid_de1,
    output logic [ROB_DEPTH-1:0] e_alloc_vec_de1,
    input  logic [ROB_DEPTH-1:0] e_valid_vec,
    input  logic [ROB_DEPTH-1:0] e_ready_vec,
    input  logic [ROB_DEPTH-1:0] e_flush_needed_vec,
    output logic [ROB_DEPTH-1:0] e_retire_vec_rb1,
    output logic                 retire_valid_rb1,
    output logic [IDW-1:0]       retire_robid_rb1,
    output logic                 q_flush_now_rb1,
    output logic                 rob_full,
    output logic                 rob_empty,
    output logic [IDW:0]         rob_count
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_retire_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);
    localparam logic [ROB_DEPTH-1:0] ONE = {{(ROB_DEPTH-1){1'b0}}, 1'b1};
    logic [IDW:0] head, tail;
    logic flush_pend, eval, retire_dec, flush_dec, ret_next;
    logic [IDW-1:0] hidx;
    assign hidx = head[IDW-1:0];
    assign rob_empty = head == tail;
    assign rob_full = (head[IDW-1:0] == tail[IDW-1:0]) && (head[IDW] != tail[IDW]);
    assign rob_count = tail - head;
    assign alloc_gnt_de1 = reset_n & alloc_req_de1 & ~rob_full & ~q_flush_now_rb1 & ~flush_pend;
    assign alloc_robid_de1 = tail[IDW-1:0];
    assign e_alloc_vec_de1 = alloc_gnt_de1 ? ONE << tail[IDW-1:0] : '0;
    assign eval = ~rob_empty & ~q_flush_now_rb1 & ~flush_pend & e_valid_vec[hidx];
    // flush_needed outranks ready on the head entry
    assign flush_dec = eval & e_flush_needed_vec[hidx];
    assign retire_dec = eval & ~e_flush_needed_vec[hidx] & e_ready_vec[hidx];
    // the mispredicting head retires alongside the flush pulse
    assign ret_next = retire_dec | flush_pend;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head             <= '0;
            tail             <= '0;
            flush_pend       <= 1'b0;
            q_flush_now_rb1  <= 1'b0;
            retire_valid_rb1 <= 1'b0;
            retire_robid_rb1 <= '0;
            e_retire_vec_rb1 <= '0;
        end else if (q_flush_now_rb1) begin
            head             <= '0;
            tail             <= '0;
            flush_pend       <= 1'b0;
            q_flush_now_rb1  <= 1'b0;
            retire_valid_rb1 <= 1'b0;
            retire_robid_rb1 <= '0;
            e_retire_vec_rb1 <= '0;
        end else begin
            flush_pend       <= flush_pend | flush_dec;
            q_flush_now_rb1  <= flush_pend;
            retire_valid_rb1 <= ret_next;
            retire_robid_rb1 <= ret_next ? hidx : '0;
            e_retire_vec_rb1 <= ret_next ? ONE << hidx : '0;
            head             <= head + (IDW+1)'(retire_dec);
            tail             <= tail + (IDW+1)'(alloc_gnt_de1);
        end
    end
`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_retire_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            perf_retire_cnt <= (retire_valid_rb1 && ~&perf_retire_cnt) ? perf_retire_cnt + 32'd1 : perf_retire_cnt;
            perf_flush_cnt  <= (q_flush_now_rb1 && ~&perf_flush_cnt) ? perf_flush_cnt + 32'd1 : perf_flush_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_rob_retire_ctl.sv
// tb_rob_retire_ctl: randomized and directed checks of rob_retire_ctl against a queue-based ROB model.
module tb_rob_retire_ctl;
    localparam int D = 16;
    logic clk = 1'b0, reset_n = 1'b0, req = 1'b0;
    logic [D-1:0] vld = '0, rdy = '0, fl = '0;
    logic gnt, rv, qf, full, empty;
    logic [3:0] robid, rid;
    logic [D-1:0] avec, rvec;
    logic [4:0] cnt;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] pr, pf;
`endif
    rob_retire_ctl dut (
        .clk(clk), .reset_n(reset_n), .alloc_req_de1(req), .alloc_gnt_de1(gnt),
        .alloc_robid_de1(robid), .e_alloc_vec_de1(avec), .e_valid_vec(vld),
        .e_ready_vec(rdy), .e_flush_needed_vec(fl), .e_retire_vec_rb1(rvec),
        .retire_valid_rb1(rv), .retire_robid_rb1(rid), .q_flush_now_rb1(qf),
        .rob_full(full), .rob_empty(empty), .rob_count(cnt)
`ifdef ROB_PERF_CNT_EN
        , .perf_retire_cnt(pr), .perf_flush_cnt(pf)
`endif
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    int q[$];
    int obs[$];
    int nid = 0, fph = 0, m_rid = 0;
    bit m_rv = 0, m_qf = 0;

    task automatic model_clear();
        q.delete();
        nid = 0; fph = 0; m_rv = 0; m_qf = 0; m_rid = 0;
        vld = '0; rdy = '0; fl = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // one clock edge; the model advances using the inputs seen just before the edge
    task automatic tick();
        bit g, ret, fdec;
        int h;
        g = reset_n && req && q.size() < D && fph == 0;
        h = q.size() > 0 ? q[0] : 0;
        ret = 0;
        fdec = 0;
        if (q.size() > 0 && fph == 0 && vld[h]) begin
            if (fl[h]) fdec = 1;
            else if (rdy[h]) ret = 1;
        end
        @(posedge clk);
        #1;
        m_rv = 0;
        m_qf = 0;
        if (fph == 2) begin
            model_clear();
        end else if (fph == 1) begin
            fph = 2; m_rv = 1; m_rid = h; m_qf = 1;
        end
        if (ret) begin
            m_rv = 1; m_rid = h;
            void'(q.pop_front());
            vld[h] = 0; rdy[h] = 0; fl[h] = 0;
        end
        if (fdec) fph = 1;
        if (g) begin
            q.push_back(nid % D);
            vld[nid % D] = 1;
            nid++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 1'b1;
        rdy = 16'($urandom);
        fl = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %0b exp 0", gnt); end
        n_chk++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%0b full=%0b exp 1/0", empty, full); end
        n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", cnt); end
        n_chk++; if (rv !== 1'b0 || qf !== 1'b0 || rvec !== '0 || rid !== 4'd0 || avec !== '0) begin n_fail++; $display("FAIL reset_outs got rv=%0b qf=%0b rvec=%h rid=%0d avec=%h exp all 0", rv, qf, rvec, rid, avec); end
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        req = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1;
            n_chk++; if (gnt !== 1'b1 || robid !== 4'(i)) begin n_fail++; $display("FAIL fill_gnt[%0d] got gnt=%0b id=%0d exp 1/%0d", i, gnt, robid, i); end
            tick();
        end
        #1;
        n_chk++; if (full !== 1'b1 || cnt !== 5'd16) begin n_fail++; $display("FAIL fill_full got full=%0b cnt=%0d exp 1/16", full, cnt); end
        n_chk++; if (gnt !== 1'b0 || avec !== '0) begin n_fail++; $display("FAIL fill_17th got gnt=%0b avec=%h exp 0/0", gnt, avec); end
        tick();
        n_chk++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL fill_hold got cnt=%0d exp 16", cnt); end
        req = 1'b0;
    endtask

    task automatic test_inorder();
        int order[4] = '{2, 0, 1, 3};
        do_reset();
        req = 1'b1;
        repeat (4) tick();
        req = 1'b0;
        obs.delete();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) rdy[order[k]] = 1'b1;
            #1;
            n_chk++; if (rv !== m_rv || (m_rv && rid !== 4'(m_rid))) begin n_fail++; $display("FAIL inorder_cyc%0d got rv=%0b id=%0d exp %0b/%0d", k, rv, rid, m_rv, m_rid); end
            if (rv === 1'b1) obs.push_back(int'(rid));
            tick();
        end
        n_chk++; if (obs.size() != 4) begin n_fail++; $display("FAIL inorder_n got %0d retires exp 4", obs.size()); end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            n_chk++; if (obs[i] != i) begin n_fail++; $display("FAIL inorder_id[%0d] got %0d exp %0d", i, obs[i], i); end
        end
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL inorder_empty got %0b exp 1", empty); end
    endtask

    task automatic test_flush();
        int pulses = 0, fid = -1;
        do_reset();
        req = 1'b1;
        repeat (5) tick();
        req = 1'b0;
        rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1; fl[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_chk++; if (rv !== m_rv || qf !== m_qf || (m_rv && rid !== 4'(m_rid))) begin n_fail++; $display("FAIL flush_cyc%0d got rv=%0b qf=%0b id=%0d exp %0b/%0b/%0d", k, rv, qf, rid, m_rv, m_qf, m_rid); end
            if (qf === 1'b1) begin pulses++; fid = int'(rid); end
            tick();
        end
        n_chk++; if (pulses != 1 || fid != 2) begin n_fail++; $display("FAIL flush_pulse got pulses=%0d id=%0d exp 1/2", pulses, fid); end
        n_chk++; if (empty !== 1'b1 || cnt !== 5'd0) begin n_fail++; $display("FAIL flush_empty got empty=%0b cnt=%0d exp 1/0", empty, cnt); end
        req = 1'b1;
        #1;
        n_chk++; if (gnt !== 1'b1 || robid !== 4'd0) begin n_fail++; $display("FAIL flush_regrant got gnt=%0b id=%0d exp 1/0", gnt, robid); end
        tick();
        req = 1'b0;
    endtask

    task automatic test_concurrent();
        do_reset();
        req = 1'b1;
        repeat (8) tick();
        #1;
        n_chk++; if (cnt !== 5'd8) begin n_fail++; $display("FAIL conc_pre got cnt=%0d exp 8", cnt); end
        rdy[0] = 1'b1;
        #1;
        n_chk++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL conc_gnt got %0b exp 1", gnt); end
        tick();
        req = 1'b0;
        #1;
        n_chk++; if (cnt !== 5'd8 || rv !== 1'b1 || rid !== 4'd0) begin n_fail++; $display("FAIL conc_count got cnt=%0d rv=%0b id=%0d exp 8/1/0", cnt, rv, rid); end
    endtask

    task automatic test_stream(input int goal, input int flush_pct, input bit seq_ids);
        bit e_gnt;
        logic [D-1:0] e_avec, e_rvec;
        int cyc = 0;
        do_reset();
        obs.delete();
        while (obs.size() < goal && cyc < 3000) begin
            req = $urandom_range(0, 99) < 60;
            for (int i = 0; i < q.size(); i++) if ($urandom_range(0, 99) < 35) rdy[q[i]] = 1'b1;
            if (flush_pct > 0 && q.size() > 0 && $urandom_range(0, 99) < flush_pct) fl[q[$urandom_range(0, q.size() - 1)]] = 1'b1;
            #1;
            e_gnt = req && q.size() < D && fph == 0;
            e_avec = e_gnt ? (16'h1 << (nid % D)) : 16'h0;
            e_rvec = m_rv ? (16'h1 << m_rid) : 16'h0;
            n_chk++; if (gnt !== e_gnt || robid !== 4'(nid % D) || avec !== e_avec) begin n_fail++; $display("FAIL stream_alloc cyc%0d got gnt=%0b id=%0d vec=%h exp %0b/%0d/%h", cyc, gnt, robid, avec, e_gnt, nid % D, e_avec); end
            n_chk++; if (cnt !== 5'(q.size()) || full !== (q.size() == D) || empty !== (q.size() == 0)) begin n_fail++; $display("FAIL stream_occ cyc%0d got cnt=%0d full=%0b empty=%0b exp cnt=%0d", cyc, cnt, full, empty, q.size()); end
            n_chk++; if (rv !== m_rv || qf !== m_qf || rvec !== e_rvec || (m_rv && rid !== 4'(m_rid))) begin n_fail++; $display("FAIL stream_ret cyc%0d got rv=%0b qf=%0b id=%0d vec=%h exp %0b/%0b/%0d/%h", cyc, rv, qf, rid, rvec, m_rv, m_qf, m_rid, e_rvec); end
            if (rv === 1'b1) obs.push_back(int'(rid));
            tick();
            cyc++;
        end
        n_chk++; if (obs.size() < goal) begin n_fail++; $display("FAIL stream_timeout got %0d retires exp %0d", obs.size(), goal); end
        if (seq_ids) begin
            for (int i = 0; i < obs.size(); i++) begin
                n_chk++; if (obs[i] != i % D) begin n_fail++; $display("FAIL wrap_id[%0d] got %0d exp %0d", i, obs[i], i % D); end
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        req = 1'b1;
        repeat (2) tick();
        req = 1'b0;
        fl[0] = 1'b1;
        tick();
        #1;
        reset_n = 1'b0;
        model_clear();
        req = 1'b1;
        #1;
        n_chk++; if (qf !== 1'b0 || rv !== 1'b0 || rvec !== '0 || gnt !== 1'b0) begin n_fail++; $display("FAIL rstflush_outs got qf=%0b rv=%0b rvec=%h gnt=%0b exp 0", qf, rv, rvec, gnt); end
        n_chk++; if (empty !== 1'b1 || cnt !== 5'd0) begin n_fail++; $display("FAIL rstflush_empty got empty=%0b cnt=%0d exp 1/0", empty, cnt); end
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (qf !== 1'b0) begin n_fail++; $display("FAIL rstflush_nopulse got %0b exp 0", qf); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_chk++; if (gnt !== 1'b1 || robid !== 4'd0) begin n_fail++; $display("FAIL rstflush_resume got gnt=%0b id=%0d exp 1/0", gnt, robid); end
        tick();
        req = 1'b0;
        #1;
        n_chk++; if (qf !== 1'b0 || cnt !== 5'd1) begin n_fail++; $display("FAIL rstflush_after got qf=%0b cnt=%0d exp 0/1", qf, cnt); end
    endtask

`ifdef ROB_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        req = 1'b1;
        repeat (10) tick();
        req = 1'b0;
        for (int i = 0; i < 9; i++) rdy[i] = 1'b1;
        fl[9] = 1'b1;
        repeat (20) tick();
        n_chk++; if (pr !== 32'd10 || pf !== 32'd1) begin n_fail++; $display("FAIL perf got retire=%0d flush=%0d exp 10/1", pr, pf); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_inorder();
        test_flush();
        test_concurrent();
        test_stream(40, 0, 1'b1);
        test_stream(200, 6, 1'b0);
        test_reset_mid_flush();
`ifdef ROB_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
